// File: rtl/memory_sub_system_param.sv
// rtl/memory_sub_system_param.sv - shared cache geometry constants and controller FSM state type
package memory_sub_system_param;

  localparam int TAG_LENGTH      = 8;
  localparam int INDEX_LENGTH    = 4;
  localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;
  localparam int ADDR_LENGTH     = TAG_LENGTH + INDEX_LENGTH;

  // Fixed encodings so older tooling and waveform filters keep decoding the state bus
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] COMPARE  = 3'd2;
  localparam logic [2:0] MEM_REQ  = 3'd3;
  localparam logic [2:0] MEM_WAIT = 3'd4;
  localparam logic [2:0] REFILL   = 3'd5;
  localparam logic [2:0] RESP     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE,
    ST_LOOKUP   = LOOKUP,
    ST_COMPARE  = COMPARE,
    ST_MEM_REQ  = MEM_REQ,
    ST_MEM_WAIT = MEM_WAIT,
    ST_REFILL   = REFILL,
    ST_RESP     = RESP
  } cache_state_t;

  function automatic logic [TAG_LENGTH-1:0] addr_tag(input logic [ADDR_LENGTH-1:0] addr);
    return addr[ADDR_LENGTH-1:INDEX_LENGTH];
  endfunction

  function automatic logic [INDEX_LENGTH-1:0] addr_index(input logic [ADDR_LENGTH-1:0] addr);
    return addr[INDEX_LENGTH-1:0];
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_valid_bits.sv
// rtl/dm_cache_ctrl_valid_bits.sv - per-line valid flags with set-by-index, clear-all and read-by-index
module valid_bits
  import memory_sub_system_param::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_en,
  input  logic [INDEX_LENGTH-1:0] set_index,
  input  logic                    clear_all,
  input  logic [INDEX_LENGTH-1:0] rd_index,
  output logic                    rd_valid
);

  logic [NUM_CACHE_LINES-1:0] valid_q;

  // Clear-all wins over a same-cycle set so a flush never leaves a stale line behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_index] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped cache lookup/refill controller (optional stats: DM_CACHE_STATS_EN)
module dm_cache_ctrl
  import memory_sub_system_param::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic                    cpu_req_write,
  input  logic [ADDR_LENGTH-1:0]  cpu_addr,
  output logic                    cpu_resp_valid,
  output logic                    cpu_resp_hit,
  input  logic                    flush,
  output logic                    tag_write,
  output logic [INDEX_LENGTH-1:0] tag_index,
  output logic [TAG_LENGTH-1:0]   tag_wdata,
  input  logic [TAG_LENGTH-1:0]   tag_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_LENGTH-1:0]  mem_req_addr,
  input  logic                    mem_resp_valid,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  cache_state_t state, state_nxt;

  logic [TAG_LENGTH-1:0]   tag_q;
  logic [INDEX_LENGTH-1:0] index_q;
  logic                    write_q;
  logic                    hit_q;
  logic                    line_valid;
  logic                    accept;
  logic                    do_flush;
  logic                    cmp_hit;

  // Flush takes the IDLE slot, so the request side is held off for that cycle
  assign do_flush      = (state == ST_IDLE) && flush;
  assign cpu_req_ready = (state == ST_IDLE) && !flush;
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign cmp_hit       = line_valid && (tag_rdata == tag_q);

  valid_bits u_valid_bits (
    .clk       (clk),
    .reset     (reset),
    .set_en    (state == ST_REFILL),
    .set_index (index_q),
    .clear_all (do_flush),
    .rd_index  (index_q),
    .rd_valid  (line_valid)
  );

  // Next-state: one request at a time, writes always go through to memory
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_LOOKUP;
      ST_LOOKUP:   state_nxt = ST_COMPARE;
      ST_COMPARE:  state_nxt = (!write_q && cmp_hit) ? ST_RESP : ST_MEM_REQ;
      ST_MEM_REQ:  if (mem_req_ready) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_resp_valid) state_nxt = write_q ? ST_RESP : ST_REFILL;
      ST_REFILL:   state_nxt = ST_RESP;
      ST_RESP:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture at acceptance and hit capture in COMPARE for the later response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q   <= '0;
      index_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) begin
        tag_q   <= addr_tag(cpu_addr);
        index_q <= addr_index(cpu_addr);
        write_q <= cpu_req_write;
      end
      if (state == ST_COMPARE) begin
        hit_q <= cmp_hit;
      end
    end
  end

  // Tag memory is addressed from the latched index so it stays put for the whole transaction
  assign tag_index      = index_q;
  assign tag_write      = (state == ST_REFILL);
  assign tag_wdata      = tag_q;

  // Memory request outputs are pure state decodes so reset drops them without waiting for an edge
  assign mem_req_valid  = (state == ST_MEM_REQ);
  assign mem_req_write  = mem_req_valid && write_q;
  assign mem_req_addr   = {tag_q, index_q};

  assign cpu_resp_valid = (state == ST_RESP);
  assign cpu_resp_hit   = (state == ST_RESP) && hit_q;

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Read-only hit/miss statistics, saturating; flush leaves them untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == ST_COMPARE && !write_q) begin
      if (cmp_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl with random traffic and reference model
module tb_dm_cache_ctrl;
  import memory_sub_system_param::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_write;
  logic [ADDR_LENGTH-1:0]  cpu_addr;
  logic                    cpu_resp_valid;
  logic                    cpu_resp_hit;
  logic                    flush;
  logic                    tag_write;
  logic [INDEX_LENGTH-1:0] tag_index;
  logic [TAG_LENGTH-1:0]   tag_wdata;
  logic [TAG_LENGTH-1:0]   tag_rdata;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_write;
  logic [ADDR_LENGTH-1:0]  mem_req_addr;
  logic                    mem_resp_valid;
  logic [31:0]             hit_count;
  logic [31:0]             miss_count;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_write  (cpu_req_write),
    .cpu_addr       (cpu_addr),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_hit   (cpu_resp_hit),
    .flush          (flush),
    .tag_write      (tag_write),
    .tag_index      (tag_index),
    .tag_wdata      (tag_wdata),
    .tag_rdata      (tag_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_seen = 0;
  int resp_cyc = 0;
  bit hold_ready = 0;
  bit hold_resp = 0;

  // Expected traffic: cpu response hit flags, {write,addr} memory requests, {index,tag} tag writes
  bit                     resp_q[$];
  logic [ADDR_LENGTH:0]   memq[$];
  logic [INDEX_LENGTH+TAG_LENGTH-1:0] tagq[$];

  // Reference cache: what the tag store should hold and which lines are live
  bit                  m_valid[NUM_CACHE_LINES];
  logic [TAG_LENGTH-1:0] m_tag[NUM_CACHE_LINES];
  int                  m_hits = 0;
  int                  m_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CACHE_LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_req(input bit w, input logic [ADDR_LENGTH-1:0] a, output bit h);
    logic [TAG_LENGTH-1:0]   t;
    logic [INDEX_LENGTH-1:0] i;
    t = a[ADDR_LENGTH-1:INDEX_LENGTH];
    i = a[INDEX_LENGTH-1:0];
    h = m_valid[i] && (m_tag[i] == t);
    if (w) begin
      memq.push_back({1'b1, a});
    end else if (h) begin
      m_hits++;
    end else begin
      m_misses++;
      memq.push_back({1'b0, a});
      tagq.push_back({i, t});
      m_valid[i] = 1'b1;
      m_tag[i] = t;
    end
    resp_q.push_back(h);
  endtask

  task automatic check_stats(input string tagname);
`ifdef DM_CACHE_STATS_EN
    chk({tagname, "_hit_count"}, hit_count, m_hits);
    chk({tagname, "_miss_count"}, miss_count, m_misses);
`else
    chk({tagname, "_hit_count"}, hit_count, 0);
    chk({tagname, "_miss_count"}, miss_count, 0);
`endif
  endtask

  task automatic send_body(input bit w, input logic [ADDR_LENGTH-1:0] a, input bit chk_lat);
    int  acc_cyc;
    int  n_resp;
    int  k;
    bit  acc;
    n_resp = resp_seen;
    acc = 0;
    acc_cyc = 0;
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_addr = a;
    for (k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = cpu_req_ready;
      acc_cyc = cyc;
      tick();
    end
    cpu_req_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", cpu_req_ready, 1);
      return;
    end
    k = 0;
    while (resp_seen == n_resp && k < 200) begin
      tick();
      k++;
    end
    chk("resp_arrived", resp_seen, n_resp + 1);
    if (chk_lat) chk("hit_latency", resp_cyc - acc_cyc, 3);
  endtask

  task automatic send(input bit w, input logic [ADDR_LENGTH-1:0] a);
    bit h;
    model_req(w, a, h);
    send_body(w, a, h && !w);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic flush_with_req(input logic [ADDR_LENGTH-1:0] a);
    bit h;
    model_clear();
    model_req(1'b0, a, h);
    flush = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_addr = a;
    @(negedge clk);
    chk("flush_blocks_ready", cpu_req_ready, 0);
    tick();
    flush = 1'b0;
    send_body(1'b0, a, 1'b0);
  endtask

  task automatic reset_mid(input bit in_wait, input logic [ADDR_LENGTH-1:0] a);
    int k;
    bit acc;
    if (in_wait) memq.push_back({1'b0, a});
    hold_ready = !in_wait;
    hold_resp = in_wait;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_addr = a;
    acc = 0;
    for (k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = cpu_req_ready;
      tick();
    end
    cpu_req_valid = 1'b0;
    k = 0;
    while (in_wait && memq.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    tick();
    tick();
    @(negedge clk);
    chk("mem_req_valid_pre_reset", mem_req_valid, !in_wait);
    #2 reset = 1'b1;
    #1;
    chk("mem_req_valid_async_drop", mem_req_valid, 0);
    chk("idle_after_reset", cpu_req_ready, 1);
    chk("no_resp_after_reset", cpu_resp_valid, 0);
    resp_q.delete();
    memq.delete();
    tagq.delete();
    model_clear();
    m_hits = 0;
    m_misses = 0;
    hold_ready = 0;
    hold_resp = 0;
    tick();
    reset = 1'b0;
    check_stats("post_reset");
  endtask

  // Cycle counter for latency measurements
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tag memory: synchronous read, data settles shortly after the edge that sampled tag_index
  initial begin
    logic [TAG_LENGTH-1:0]   tmem[NUM_CACHE_LINES];
    logic [INDEX_LENGTH-1:0] idx;
    logic [TAG_LENGTH-1:0]   wd;
    logic                    we;
    for (int i = 0; i < NUM_CACHE_LINES; i++) tmem[i] = '0;
    tag_rdata = '0;
    forever begin
      @(posedge clk);
      idx = tag_index;
      we = tag_write;
      wd = tag_wdata;
      #1;
      if (we) tmem[idx] = wd;
      tag_rdata = tmem[idx];
    end
  end

  // Main memory responder: random ready stall, random completion delay, stray completions while idle
  initial begin
    bit pend;
    bit hs;
    int cnt;
    pend = 0;
    hs = 0;
    cnt = 0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pend = 0;
        hs = 0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
      end else begin
        mem_resp_valid = 1'b0;
        if (hs) begin
          pend = 1;
          cnt = $urandom_range(0, 3);
        end
        if (pend) begin
          if (cnt > 0) cnt--;
          else if (!hold_resp) begin
            mem_resp_valid = 1'b1;
            pend = 0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          mem_resp_valid = 1'b1;
        end
        mem_req_ready = mem_req_valid && !pend && !hold_ready && ($urandom_range(0, 2) != 0);
        hs = mem_req_ready;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response, memory request or tag write
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (cpu_resp_valid) begin
        resp_seen++;
        resp_cyc = cyc;
        if (resp_q.size() == 0) chk("unexpected_resp", cpu_resp_valid, 0);
        else chk("resp_hit", cpu_resp_hit, resp_q.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        if (memq.size() == 0) chk("unexpected_mem_req", mem_req_valid, 0);
        else chk("mem_req_write_addr", {mem_req_write, mem_req_addr}, memq.pop_front());
      end
      if (tag_write) begin
        if (tagq.size() == 0) chk("unexpected_tag_write", tag_write, 0);
        else chk("tag_write_index_data", {tag_index, tag_wdata}, tagq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_LENGTH-1:0] a;
    bit w;
    reset = 1'b1;
    flush = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_addr = '0;
    model_clear();
    for (int i = 0; i < NUM_CACHE_LINES; i++) m_tag[i] = '0;
    tick();
    tick();
    #1;
    chk("rst_cpu_req_ready", cpu_req_ready, 1);
    chk("rst_cpu_resp_valid", cpu_resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_write", mem_req_write, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_tag_write", tag_write, 0);
    chk("rst_tag_index", tag_index, 0);
    chk("rst_tag_wdata", tag_wdata, 0);
    check_stats("rst");
    tick();
    reset = 1'b0;
    tick();

    send(1'b0, {8'h12, 4'd3});
    check_stats("first_miss");
    send(1'b0, {8'h12, 4'd3});
    check_stats("repeat_hit");
    send(1'b0, {8'h13, 4'd3});
    send(1'b1, {8'h13, 4'd3});
    send(1'b0, {8'h13, 4'd3});
    send(1'b0, {8'h12, 4'd3});
    flush_with_req({8'h12, 4'd3});
    check_stats("directed");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        w = ($urandom_range(0, 3) == 0);
        a = {8'($urandom_range(8'h10, 8'h13)), 4'($urandom_range(0, 15))};
        send(w, a);
      end
    end
    check_stats("random");

    send(1'b0, {8'h13, 4'd3});
    reset_mid(1'b1, {8'h40, 4'd5});
    send(1'b0, {8'h13, 4'd3});
    check_stats("after_wait_reset");
    send(1'b0, {8'h21, 4'd7});
    reset_mid(1'b0, {8'h41, 4'd6});
    send(1'b0, {8'h21, 4'd7});
    send(1'b0, {8'h21, 4'd7});
    check_stats("after_req_reset");

    tick();
    tick();
    chk("resp_q_drained", resp_q.size(), 0);
    chk("memq_drained", memq.size(), 0);
    chk("tagq_drained", tagq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
